dcache_req_ctrl: RTL and testbench

- Sits between the MEM stage's combinational dcache request outputs and the data cache.
- Registers each load/store request once and holds it stable until the dcache responds.
- Stalls the pipeline while the request is outstanding, then captures read data so the MEM stage sees stable data until the pipeline advances.
- Keeps saturating performance counters for dcache requests and MEM stall cycles.

---
 rtl/dcache_req_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_req_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_ctrl.sv
// dcache_req_ctrl
//   Request controller between the MEM stage and the data cache. A load or
//   store seen in IDLE is registered once and presented to the dcache from
//   those registers until the dcache answers. While the request is
//   outstanding the MEM stage is stalled. Read data is bypassed on the
//   response cycle and captured so the MEM stage keeps seeing it until the
//   pipeline advances. Two saturating counters track issued requests and
//   stalled cycles.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req_read, req_write      MEM stage load/store request (held while in MEM)
//   req_addr, req_wdata      MEM stage word address and store data
//   req_byte_enable          MEM stage store byte enables
//   pipe_advance             MEM instruction leaves at this edge
//   mem_read, mem_write      dcache strobes
//   mem_address              dcache address (bits [1:0] always 0)
//   mem_wdata                dcache write data
//   mem_byte_enable          dcache byte enables
//   mem_resp, mem_rdata      dcache completion pulse and read data
//   rdata_out                read data returned to the MEM stage
//   mem_stall                MEM stage not ready
//   req_count, stall_count   saturating performance counters

module dcache_req_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_byte_enable,
  input  logic             pipe_advance,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_byte_enable,
  input  logic             mem_resp,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      rdata_out,
  output logic             mem_stall,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             op_write_q, op_write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_int;
  logic             req_any;

  assign req_any = req_read | req_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      req_cnt_q   <= req_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    req_cnt_d   = req_cnt_q;
    stall_cnt_d = stall_cnt_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    stall_int   = 1'b0;
    rdata_out   = rdata_q;

    case (state_q)
      IDLE: begin
        stall_int = req_any;
        if (req_any) begin
          state_d    = BUSY;
          // A simultaneous read and write request is issued as a write.
          op_write_d = req_write;
          addr_d     = req_addr & 32'hFFFF_FFFC;
          wdata_d    = req_wdata;
          be_d       = req_byte_enable;
          if (req_cnt_q != CNT_MAX) req_cnt_d = req_cnt_q + CNT_ONE;
        end
      end
      BUSY: begin
        mem_read  = ~op_write_q;
        mem_write = op_write_q;
        stall_int = ~mem_resp;
        if (mem_resp) begin
          // Bypass so the MEM stage can leave on the response cycle.
          rdata_out = mem_rdata;
          rdata_d   = mem_rdata;
          state_d   = pipe_advance ? IDLE : DONE;
        end
      end
      DONE: begin
        // Request already served; req_* still high must not reissue it.
        if (pipe_advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (stall_int && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  // Stall is masked by reset so every output is 0 while reset is held,
  // even when the MEM stage keeps its request asserted.
  assign mem_stall       = stall_int & rst;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign req_count       = req_cnt_q;
  assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_dcache_req_ctrl.sv
module tb_dcache_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_enable;
  logic        pipe_advance;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  logic        mem_read, mem_write, mem_stall;
  logic [31:0] mem_address, mem_wdata, rdata_out;
  logic [3:0]  mem_byte_enable;
  logic [31:0] req_count, stall_count;

  logic        s_mem_read, s_mem_write, s_mem_stall;
  logic [31:0] s_mem_address, s_mem_wdata, s_rdata_out;
  logic [3:0]  s_mem_byte_enable;
  logic [3:0]  s_req_count, s_stall_count;

  int checks;
  int failures;

  dcache_req_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .pipe_advance(pipe_advance),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .rdata_out(rdata_out), .mem_stall(mem_stall),
    .req_count(req_count), .stall_count(stall_count)
  );

  dcache_req_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .pipe_advance(pipe_advance),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_address(s_mem_address),
    .mem_wdata(s_mem_wdata), .mem_byte_enable(s_mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .rdata_out(s_rdata_out), .mem_stall(s_mem_stall),
    .req_count(s_req_count), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        adv;
    logic        resp;
    logic [31:0] rdata;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic        e_stall;
    logic [31:0] e_rd;
    logic [31:0] e_rc;
    logic [31:0] e_sc;
  } vec_t;

  vec_t vecs[17];

  task automatic applyStimulus(input vec_t v);
    req_read        = v.rr;
    req_write       = v.rw;
    req_addr        = v.addr;
    req_wdata       = v.wd;
    req_byte_enable = v.be;
    pipe_advance    = v.adv;
    mem_resp        = v.resp;
    mem_rdata       = v.rdata;
  endtask

  task automatic drive(input logic rr, input logic rw, input logic [31:0] addr,
                       input logic adv, input logic resp, input logic [31:0] rdata);
    req_read        = rr;
    req_write       = rw;
    req_addr        = addr;
    req_wdata       = 32'h0;
    req_byte_enable = 4'h0;
    pipe_advance    = adv;
    mem_resp        = resp;
    mem_rdata       = rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            rr    rw    addr          wd            be    adv   resp  rdata          mr    mw    e_addr        e_wd          e_be  stall e_rd          rc  sc
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_1006, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_1006, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF, 1, 1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF, 1, 1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_2003, 32'h0000_00AB, 4'h4, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF, 1, 1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_3000, 32'h0000_00FF, 4'hF, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_00AB, 4'h4, 1'b1, 32'hDEAD_BEEF, 2, 2};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_3000, 32'h0000_00FF, 4'hF, 1'b1, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_00AB, 4'h4, 1'b0, 32'h5555_5555, 2, 3};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_00AB, 4'h4, 1'b1, 32'h5555_5555, 2, 3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b0, 32'h1111_1111, 3, 4};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b1, 32'h1111_1111, 3, 4};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b0, 32'h2222_2222, 4, 5};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_020A, 32'h0000_CAFE, 4'h3, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b1, 32'h2222_2222, 4, 5};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_020A, 32'h0000_CAFE, 4'h3, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'h0000_0208, 32'h0000_CAFE, 4'h3, 1'b0, 32'h3333_3333, 5, 6};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_020A, 32'h0000_CAFE, 4'h3, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0208, 32'h0000_CAFE, 4'h3, 1'b0, 32'h3333_3333, 5, 6};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_020A, 32'h0000_CAFE, 4'h3, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0208, 32'h0000_CAFE, 4'h3, 1'b0, 32'h3333_3333, 5, 6};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0208, 32'h0000_CAFE, 4'h3, 1'b0, 32'h3333_3333, 5, 6};

    // Reset with a request pending: every output must be 0.
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("reset_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("reset_read", {31'h0, mem_read}, 32'h0);
    checkOutput("reset_rdata", rdata_out, 32'h0);
    checkOutput("reset_req_count", req_count, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b1;

    // Table-driven cycles: checks sampled mid-cycle, then the clock edge.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      #3;
      checkOutput($sformatf("v%0d_mem_read", i), {31'h0, mem_read}, {31'h0, vecs[i].e_mr});
      checkOutput($sformatf("v%0d_mem_write", i), {31'h0, mem_write}, {31'h0, vecs[i].e_mw});
      checkOutput($sformatf("v%0d_mem_address", i), mem_address, vecs[i].e_addr);
      checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wd);
      checkOutput($sformatf("v%0d_mem_be", i), {28'h0, mem_byte_enable}, {28'h0, vecs[i].e_be});
      checkOutput($sformatf("v%0d_mem_stall", i), {31'h0, mem_stall}, {31'h0, vecs[i].e_stall});
      checkOutput($sformatf("v%0d_rdata_out", i), rdata_out, vecs[i].e_rd);
      checkOutput($sformatf("v%0d_req_count", i), req_count, vecs[i].e_rc);
      checkOutput($sformatf("v%0d_stall_count", i), stall_count, vecs[i].e_sc);
      step();
    end

    // Long-latency load: response on the 10th BUSY cycle, then 3 DONE cycles.
    drive(1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("long_latch_stall", {31'h0, mem_stall}, 32'h1);
    step();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 32'h0000_0400 + 32'((i + 1) * 16), 1'b1, 1'b0, 32'hBAD0_0000);
      #3;
      checkOutput($sformatf("long_busy%0d_read", i), {31'h0, mem_read}, 32'h1);
      checkOutput($sformatf("long_busy%0d_addr", i), mem_address, 32'h0000_0400);
      checkOutput($sformatf("long_busy%0d_stall", i), {31'h0, mem_stall}, 32'h1);
      step();
    end
    drive(1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b1, 32'h4444_4444);
    #3;
    checkOutput("long_resp_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("long_resp_bypass", rdata_out, 32'h4444_4444);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
      #3;
      checkOutput($sformatf("done%0d_read", i), {31'h0, mem_read}, 32'h0);
      checkOutput($sformatf("done%0d_stall", i), {31'h0, mem_stall}, 32'h0);
      checkOutput($sformatf("done%0d_rdata", i), rdata_out, 32'h4444_4444);
      checkOutput($sformatf("done%0d_req_count", i), req_count, 32'd6);
      step();
    end
    drive(1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("long_end_req_count", req_count, 32'd6);
    checkOutput("long_end_stall_count", stall_count, 32'd16);
    step();

    // Asynchronous reset in the middle of BUSY, away from any clock edge.
    drive(1'b1, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    checkOutput("pre_reset_read", {31'h0, mem_read}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_read", {31'h0, mem_read}, 32'h0);
    checkOutput("async_reset_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("async_reset_req_count", req_count, 32'h0);
    checkOutput("async_reset_stall_count", stall_count, 32'h0);
    checkOutput("async_reset_addr", mem_address, 32'h0);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h9999_9999);
    #3;
    checkOutput("stray_resp_rdata", rdata_out, 32'h0);
    checkOutput("stray_resp_stall", {31'h0, mem_stall}, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("after_stray_rdata", rdata_out, 32'h0);
    checkOutput("after_stray_read", {31'h0, mem_read}, 32'h0);
    checkOutput("after_stray_req_count", req_count, 32'h0);
    step();

    // 20 stalled cycles: the 4-bit counter saturates at 15.
    drive(1'b1, 1'b0, 32'h0000_0600, 1'b0, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 19; i++) step();
    drive(1'b1, 1'b0, 32'h0000_0600, 1'b1, 1'b1, 32'h7777_7777);
    #3;
    checkOutput("sat_main_stall_count", stall_count, 32'd20);
    checkOutput("sat_small_stall_count", {28'h0, s_stall_count}, 32'd15);
    checkOutput("sat_small_req_count", {28'h0, s_req_count}, 32'd1);
    checkOutput("sat_small_read", {31'h0, s_mem_read}, 32'h1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("sat_hold_small", {28'h0, s_stall_count}, 32'd15);
    checkOutput("sat_hold_main", stall_count, 32'd20);
    checkOutput("sat_rdata", rdata_out, 32'h7777_7777);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
